vga_pixel_locator: RTL
======================

Name: vga_pixel_locator

Overview:
- Video-side receiver for the VGA pixel emulator: monitors the 50 MHz-domain VGA output bus and decodes it back into the drawn pixel coordinate.
- Recovers horizontal and vertical position from BLANK_n/VS edges and captures the first lit pixel of each frame as (x, y).
- Counts lit samples per frame and checks line and frame geometry against expected 640x480 timing.
- Used as the on-chip loopback checker for the coordinate path and as the reference model's hardware twin in system benches.

Parameters:
- LIT_THRESH, 8'h80, a sample is lit when any of R/G/B >= LIT_THRESH.
- EXP_HTOTAL, 1600, expected clk50 cycles between successive BLANK_n rising edges.
- EXP_HACTIVE, 1280, expected clk50 cycles of BLANK_n high per line.
- EXP_VACTIVE, 480, expected active lines between VS falling edges.

Ports:
- clk50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- vga_r, vga_g, vga_b  in  8 each  colour channels from emulator
- vga_hs  in  1  horizontal sync, active low
- vga_vs  in  1  vertical sync, active low
- vga_blank_n  in  1  high during active video
- locked  out  1  geometry verified for one complete frame
- frame_done  out  1  one-cycle pulse at frame close, outputs below updated same cycle
- hit_valid  out  1  last closed frame contained a lit sample
- hit_x  out  11  clk50-unit column of first lit sample, 0..1279
- hit_y  out  10  active line of first lit sample, 0..479
- lit_count  out  20  lit samples in last closed frame, saturating
- err_htotal, err_hactive, err_vactive  out  1 each  sticky geometry errors

Behaviour:
- Reset: all outputs 0, all counters 0, state ACQUIRE.
- Input stage: all inputs registered once (s_*); a second register (s_*_d) is used for edge detection. Total input latency is 2 cycles; positions are defined against the s_* sample.
- blank_rise = s_blank & !s_blank_d; blank_fall = !s_blank & s_blank_d; vs_fall = !s_vs & s_vs_d.
- h_pos (11 b): 0 on blank_rise, else +1 while s_blank; holds while blank. The sample at blank_rise has x = 0.
- line_per (12 b): cycles between blank_rise events; 0 on blank_rise, else +1, saturating at 4095.
- v_line (10 b): cleared on vs_fall, +1 on blank_fall, saturating at 1023.
- lit = s_blank & (s_r >= LIT_THRESH | s_g >= LIT_THRESH | s_b >= LIT_THRESH).
- First lit sample in a frame latches (h_pos, v_line) into a working pair and sets found. Later lit samples only increment the working count, saturating at 2^20-1.
- On blank_rise (except the first after vs_fall), check line_per == EXP_HTOTAL-1 (counter value before clear), else set pending htotal error.
- On blank_fall, check h_pos == EXP_HACTIVE-1, else set pending hactive error.
- On vs_fall, check v_line == EXP_VACTIVE, else set pending vactive error.
- FSM:
  - ACQUIRE: discard everything; on vs_fall go to MEASURE and clear working state.
  - MEASURE: on vs_fall, if no pending error go to TRACK and set locked; else stay in MEASURE. frame_done does not pulse.
  - TRACK: on vs_fall, pulse frame_done, publish hit_valid=found, hit_x/hit_y (held if !found), lit_count, and OR pending errors into the sticky err_* outputs; if any error occurred, clear locked and go to MEASURE.
- Every vs_fall clears the working state and pending errors in the same cycle as publication.
- Simultaneous lit and blank_fall in the same cycle: not possible, since lit requires s_blank. Simultaneous vs_fall and blank edge: the edge is processed against the old frame before the clear.
- Sticky err_* clear only on reset.
- Async reset mid-frame returns to ACQUIRE; no frame_done until two full VS periods after release.

Decomposition:
- Package vga_pkg: timing constants (HTOTAL 1600, HACTIVE 1280, VACTIVE 480, VTOTAL 525), coordinate typedefs xcoord_t [10:0] and ycoord_t [9:0], and FSM enum lock_state_t.
- One sub-module, vga_edge_sync: registers the sync/blank/colour inputs and emits the three edge strobes. Counters, capture logic and FSM stay in the top level.

Test Plan:
- Emulator with x_coor=0, y_coor=0: after 2 frames, locked=1; the next frame_done gives hit_valid=1, hit=(0,0), lit_count=1.
- x_coor=1279, y_coor=479: hit=(1279,479), lit_count=1, no err_* set.
- x_coor=1400 (outside active region): hit_valid=0, lit_count=0, locked stays 1.
- Colour forced to 8'h7F on all channels across the whole screen: lit_count=0. Forced to 8'h80 on G across the whole screen: lit_count=614400, hit=(0,0).
- Stretch one line to 1602 cycles mid-frame: err_htotal=1 at that frame's frame_done, locked falls to 0, then relocks one clean frame later with err_htotal still 1.
- Assert reset for 3 cycles mid-frame: all outputs 0; frame_done first pulses at the third vs_fall after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants, coordinate types and lock-FSM states for the
// VGA loopback receiver.
package vga_pkg;

    // Nominal 640x480 geometry expressed in clk50 cycles / lines.
    localparam int HTOTAL  = 1600;
    localparam int HACTIVE = 1280;
    localparam int VACTIVE = 480;
    localparam int VTOTAL  = 525;

    // Default lit threshold applied to each colour channel.
    localparam logic [7:0] LIT_THRESH_DEFAULT = 8'h80;

    typedef logic [10:0] xcoord_t;
    typedef logic [9:0]  ycoord_t;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        MEASURE = 2'd1,
        TRACK   = 2'd2
    } lock_state_t;

endpackage

// File: rtl/vga_edge_sync.sv
// Input stage: samples the VGA bus once (s_*), keeps a second copy (s_*_d)
// and derives the blank/vsync edge strobes from the pair.
module vga_edge_sync (
    input  logic       clk50,
    input  logic       reset,
    input  logic [7:0] vga_r,
    input  logic [7:0] vga_g,
    input  logic [7:0] vga_b,
    input  logic       vga_hs,
    input  logic       vga_vs,
    input  logic       vga_blank_n,
    output logic [7:0] s_r,
    output logic [7:0] s_g,
    output logic [7:0] s_b,
    output logic       s_blank,
    output logic       blank_rise,
    output logic       blank_fall,
    output logic       vs_fall
);

    logic s_hs;
    logic s_vs;
    logic s_vs_d;
    logic s_blank_d;

    // Syncs idle high out of reset so release never fakes a vsync edge.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            s_r       <= '0;
            s_g       <= '0;
            s_b       <= '0;
            s_hs      <= 1'b1;
            s_vs      <= 1'b1;
            s_blank   <= 1'b0;
            s_vs_d    <= 1'b1;
            s_blank_d <= 1'b0;
        end else begin
            s_r       <= vga_r;
            s_g       <= vga_g;
            s_b       <= vga_b;
            s_hs      <= vga_hs;
            s_vs      <= vga_vs;
            s_blank   <= vga_blank_n;
            s_vs_d    <= s_vs;
            s_blank_d <= s_blank;
        end
    end

    // Line geometry is taken from blank_n; hsync is sampled but not decoded.
    logic unused_hs;
    assign unused_hs = s_hs;

    assign blank_rise =  s_blank & ~s_blank_d;
    assign blank_fall = ~s_blank &  s_blank_d;
    assign vs_fall    = ~s_vs    &  s_vs_d;

endmodule

// File: rtl/vga_pixel_locator.sv
// Decodes the VGA output bus back into the first lit pixel of each frame,
// counts lit samples and verifies line/frame geometry.
//
// Output handshake: frame_done is a one-cycle valid strobe with no ready;
// hit_valid, hit_x, hit_y, lit_count and err_* change only in the cycle
// frame_done is high and are stable until the next strobe.
module vga_pixel_locator
    import vga_pkg::*;
#(
    parameter logic [7:0] LIT_THRESH  = LIT_THRESH_DEFAULT,
    parameter int          EXP_HTOTAL  = HTOTAL,
    parameter int          EXP_HACTIVE = HACTIVE,
    parameter int          EXP_VACTIVE = VACTIVE
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic        vga_blank_n,
    output logic        locked,
    output logic        frame_done,
    output logic        hit_valid,
    output xcoord_t     hit_x,
    output ycoord_t     hit_y,
    output logic [19:0] lit_count,
    output logic        err_htotal,
    output logic        err_hactive,
    output logic        err_vactive,
    output lock_state_t dbg_state
);

    logic [7:0] s_r, s_g, s_b;
    logic       s_blank, blank_rise, blank_fall, vs_fall;

    vga_edge_sync u_sync (
        .clk50       (clk50),
        .reset       (reset),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .s_r         (s_r),
        .s_g         (s_g),
        .s_b         (s_b),
        .s_blank     (s_blank),
        .blank_rise  (blank_rise),
        .blank_fall  (blank_fall),
        .vs_fall     (vs_fall)
    );

    xcoord_t     h_pos, h_now;
    logic [11:0] line_per;
    ycoord_t     v_line, v_now;
    logic        first_rise;
    logic        lit;

    logic        found, found_n;
    xcoord_t     w_x, w_x_n;
    ycoord_t     w_y, w_y_n;
    logic [19:0] w_count, w_count_n;

    logic        pend_htotal, pend_hactive, pend_vactive;
    logic        pend_htotal_n, pend_hactive_n, pend_vactive_n;
    logic        any_err;

    lock_state_t state, state_next;
    logic        publish, lock_set, lock_clr;

    // Column of the current s_* sample: the sample at blank_rise is x = 0.
    assign h_now = blank_rise ? '0 : h_pos + 1'b1;

    // Line index as seen after this cycle's blank_fall, so a coincident
    // vs_fall judges the old frame including that edge.
    assign v_now = (blank_fall && v_line != '1) ? v_line + 1'b1 : v_line;

    assign lit = s_blank & ((s_r >= LIT_THRESH) | (s_g >= LIT_THRESH) |
                            (s_b >= LIT_THRESH));

    // Working capture and pending errors as they stand after this cycle.
    always_comb begin
        found_n        = found | lit;
        w_x_n          = w_x;
        w_y_n          = w_y;
        w_count_n      = w_count;
        pend_htotal_n  = pend_htotal;
        pend_hactive_n = pend_hactive;
        pend_vactive_n = pend_vactive;
        if (lit && !found) begin
            w_x_n = h_now;
            w_y_n = v_line;
        end
        if (lit && w_count != 20'hFFFFF) begin
            w_count_n = w_count + 1'b1;
        end
        if (blank_rise && !first_rise && line_per != 12'(EXP_HTOTAL - 1)) begin
            pend_htotal_n = 1'b1;
        end
        if (blank_fall && h_pos != xcoord_t'(EXP_HACTIVE - 1)) begin
            pend_hactive_n = 1'b1;
        end
        if (vs_fall && v_now != ycoord_t'(EXP_VACTIVE)) begin
            pend_vactive_n = 1'b1;
        end
    end

    assign any_err = pend_htotal_n | pend_hactive_n | pend_vactive_n;

    // Horizontal/vertical position and line-period counters.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            h_pos      <= '0;
            line_per   <= '0;
            v_line     <= '0;
            first_rise <= 1'b1;
        end else begin
            if (s_blank) begin
                h_pos <= h_now;
            end
            if (blank_rise) begin
                line_per <= '0;
            end else if (line_per != 12'hFFF) begin
                line_per <= line_per + 1'b1;
            end
            v_line <= vs_fall ? '0 : v_now;
            if (vs_fall) begin
                first_rise <= 1'b1;
            end else if (blank_rise) begin
                first_rise <= 1'b0;
            end
        end
    end

    // Working capture and pending errors, cleared at every vs_fall.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            found        <= 1'b0;
            w_x          <= '0;
            w_y          <= '0;
            w_count      <= '0;
            pend_htotal  <= 1'b0;
            pend_hactive <= 1'b0;
            pend_vactive <= 1'b0;
        end else if (vs_fall) begin
            found        <= 1'b0;
            w_x          <= '0;
            w_y          <= '0;
            w_count      <= '0;
            pend_htotal  <= 1'b0;
            pend_hactive <= 1'b0;
            pend_vactive <= 1'b0;
        end else begin
            found        <= found_n;
            w_x          <= w_x_n;
            w_y          <= w_y_n;
            w_count      <= w_count_n;
            pend_htotal  <= pend_htotal_n;
            pend_hactive <= pend_hactive_n;
            pend_vactive <= pend_vactive_n;
        end
    end

    // Lock FSM state register.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state <= ACQUIRE;
        end else begin
            state <= state_next;
        end
    end

    // Lock FSM transitions; every decision is taken at vs_fall.
    always_comb begin
        state_next = state;
        publish    = 1'b0;
        lock_set   = 1'b0;
        lock_clr   = 1'b0;
        if (vs_fall) begin
            case (state)
                ACQUIRE: state_next = MEASURE;
                MEASURE: begin
                    if (!any_err) begin
                        state_next = TRACK;
                        lock_set   = 1'b1;
                    end
                end
                TRACK: begin
                    publish = 1'b1;
                    if (any_err) begin
                        state_next = MEASURE;
                        lock_clr   = 1'b1;
                    end
                end
                default: state_next = ACQUIRE;
            endcase
        end
    end

    assign dbg_state = state;

    // Published results, lock flag and sticky error outputs.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            locked      <= 1'b0;
            frame_done  <= 1'b0;
            hit_valid   <= 1'b0;
            hit_x       <= '0;
            hit_y       <= '0;
            lit_count   <= '0;
            err_htotal  <= 1'b0;
            err_hactive <= 1'b0;
            err_vactive <= 1'b0;
        end else begin
            frame_done <= publish;
            if (lock_set) begin
                locked <= 1'b1;
            end else if (lock_clr) begin
                locked <= 1'b0;
            end
            if (publish) begin
                hit_valid <= found_n;
                if (found_n) begin
                    hit_x <= w_x_n;
                    hit_y <= w_y_n;
                end
                lit_count   <= w_count_n;
                err_htotal  <= err_htotal  | pend_htotal_n;
                err_hactive <= err_hactive | pend_hactive_n;
                err_vactive <= err_vactive | pend_vactive_n;
            end
        end
    end

endmodule
